// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
//
// Receive-side VGA timing decoder. It consumes hSync/vSync/video_on, recovers
// the pixel column/row, measures the line and frame lengths, and declares lock
// once LOCK_FRAMES consecutive frames conform to the expected timing.
//
// Parameters:
//   H_TOTAL      expected clocks per line (hsync fall to hsync fall)
//   V_TOTAL      expected lines per frame (vsync fall to vsync fall)
//   H_VISIBLE    expected video_on run length on an active line
//   V_VISIBLE    expected active lines per frame
//   LOCK_FRAMES  consecutive good frames needed for lock (1..15)
//
// Ports:
//   clk_25        in   pixel clock, all inputs synchronous to it
//   rst_n         in   asynchronous active-low reset
//   hSync         in   horizontal sync, active low
//   vSync         in   vertical sync, active low
//   video_on      in   active-video enable
//   pixel_valid   out  video_on delayed one clock
//   x             out  pixel column within the active line
//   y             out  active line index within the frame
//   frame_start   out  one-cycle pulse after a vsync falling edge
//   locked        out  timing conforms to the parameters
//   h_total_meas  out  last measured line length, saturates at 1023
//   v_total_meas  out  last measured frame length in lines, saturates at 1023
//   err_count     out  bad line + bad frame count (only with VGA_DEC_STATS_EN)
//
// Build option:
//   VGA_DEC_STATS_EN  when defined, err_count is a saturating count of bad
//                     lines plus bad frames since reset; otherwise it is 0.
// -----------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_VISIBLE   = 640,
  parameter int V_VISIBLE   = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk_25,
  input  logic       rst_n,
  input  logic       hSync,
  input  logic       vSync,
  input  logic       video_on,
  output logic       pixel_valid,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] h_total_meas,
  output logic [9:0] v_total_meas,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [10:0] H_TOTAL_W   = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_W   = 11'(V_TOTAL);
  localparam logic [10:0] H_VISIBLE_W = 11'(H_VISIBLE);
  localparam logic [9:0]  V_VISIBLE_W = 10'(V_VISIBLE);
  localparam logic [4:0]  LOCK_W      = 5'(LOCK_FRAMES);

  // ---------------------------------------------------------------------------
  // Input edge detection
  // ---------------------------------------------------------------------------
  logic hs_d_reg;
  logic vs_d_reg;
  logic de_d_reg;
  logic hfall;
  logic vfall;
  logic derise;
  logic defall;

  assign hfall  = hs_d_reg & ~hSync;
  assign vfall  = vs_d_reg & ~vSync;
  assign derise = ~de_d_reg & video_on;
  assign defall = de_d_reg & ~video_on;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      hs_d_reg <= 1'b1;
      vs_d_reg <= 1'b1;
      de_d_reg <= 1'b0;
    end else begin
      hs_d_reg <= hSync;
      vs_d_reg <= vSync;
      de_d_reg <= video_on;
    end
  end

  // ---------------------------------------------------------------------------
  // Line / frame measurement
  // ---------------------------------------------------------------------------
  logic [9:0]  h_cnt_reg, h_cnt_next;
  logic [9:0]  v_cnt_reg, v_cnt_next;
  logic [10:0] de_run_reg, de_run_next;
  logic [9:0]  act_lines_reg, act_lines_next;
  logic [9:0]  h_total_meas_reg, h_total_meas_next;
  logic [9:0]  v_total_meas_reg, v_total_meas_next;
  logic        frame_err_reg, frame_err_next;
  logic [10:0] h_len;
  logic [10:0] v_len;
  logic        line_bad_h;
  logic        line_bad_de;
  logic        bad_line;
  logic        frame_bad;
  logic        sync_lost;

  // Length of the line closing at this hfall, and of the frame closing at this
  // vfall. A coincident hfall belongs to the closing frame.
  assign h_len = {1'b0, h_cnt_reg} + 11'd1;
  assign v_len = {1'b0, v_cnt_reg} + {10'd0, hfall};

  assign line_bad_h  = hfall && (h_len != H_TOTAL_W);
  assign line_bad_de = defall && (de_run_reg != H_VISIBLE_W);
  assign bad_line    = line_bad_h | line_bad_de;
  assign frame_bad   = vfall && ((v_len != V_TOTAL_W) ||
                                 (act_lines_reg != V_VISIBLE_W) ||
                                 frame_err_reg || bad_line);

  // A line counter parked at its ceiling means hsync has stopped. An hfall in
  // that same cycle already restarts the line, so it does not count as lost.
  assign sync_lost = (h_cnt_reg == 10'h3FF) && !hfall;

  always_comb begin
    h_cnt_next        = h_cnt_reg;
    v_cnt_next        = v_cnt_reg;
    de_run_next       = de_run_reg;
    act_lines_next    = act_lines_reg;
    h_total_meas_next = h_total_meas_reg;
    v_total_meas_next = v_total_meas_reg;
    frame_err_next    = frame_err_reg | bad_line;

    if (hfall) begin
      h_cnt_next        = 10'd0;
      h_total_meas_next = h_len[10] ? 10'h3FF : h_len[9:0];
    end else if (h_cnt_reg != 10'h3FF) begin
      h_cnt_next = h_cnt_reg + 10'd1;
    end

    if (vfall) begin
      v_cnt_next        = 10'd0;
      v_total_meas_next = v_len[10] ? 10'h3FF : v_len[9:0];
      frame_err_next    = 1'b0;
    end else if (hfall && (v_cnt_reg != 10'h3FF)) begin
      v_cnt_next = v_cnt_reg + 10'd1;
    end

    // Run length of the current video_on burst; holds its value after defall
    // so the closing length is visible in the defall cycle.
    if (video_on) begin
      if (!de_d_reg) begin
        de_run_next = 11'd1;
      end else if (de_run_reg != 11'h7FF) begin
        de_run_next = de_run_reg + 11'd1;
      end
    end

    // A derise coincident with vfall opens the new frame's first active line.
    if (vfall) begin
      act_lines_next = derise ? 10'd1 : 10'd0;
    end else if (derise && (act_lines_reg != 10'h3FF)) begin
      act_lines_next = act_lines_reg + 10'd1;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg        <= 10'd0;
      v_cnt_reg        <= 10'd0;
      de_run_reg       <= 11'd0;
      act_lines_reg    <= 10'd0;
      h_total_meas_reg <= 10'd0;
      v_total_meas_reg <= 10'd0;
      frame_err_reg    <= 1'b0;
    end else begin
      h_cnt_reg        <= h_cnt_next;
      v_cnt_reg        <= v_cnt_next;
      de_run_reg       <= de_run_next;
      act_lines_reg    <= act_lines_next;
      h_total_meas_reg <= h_total_meas_next;
      v_total_meas_reg <= v_total_meas_next;
      frame_err_reg    <= frame_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel coordinate path (one clock latency)
  // ---------------------------------------------------------------------------
  logic       pixel_valid_reg;
  logic [9:0] x_reg, x_next;
  logic [8:0] y_reg, y_next;
  logic       y_first_reg, y_first_next;
  logic       frame_start_reg;

  always_comb begin
    x_next       = x_reg;
    y_next       = y_reg;
    y_first_next = y_first_reg;

    if (video_on) begin
      x_next = de_d_reg ? (x_reg + 10'd1) : 10'd0;
    end

    // y_first marks that the next derise is the first active line of a frame.
    if (derise) begin
      y_next       = (y_first_reg || vfall) ? 9'd0 : (y_reg + 9'd1);
      y_first_next = 1'b0;
    end else if (vfall) begin
      y_first_next = 1'b1;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid_reg <= 1'b0;
      x_reg           <= 10'd0;
      y_reg           <= 9'd0;
      y_first_reg     <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      pixel_valid_reg <= video_on;
      x_reg           <= x_next;
      y_reg           <= y_next;
      y_first_reg     <= y_first_next;
      frame_start_reg <= vfall;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [3:0] good_frames_reg, good_frames_next;

  always_comb begin
    state_next       = state_reg;
    good_frames_next = good_frames_reg;

    if (sync_lost) begin
      state_next       = SEARCH;
      good_frames_next = 4'd0;
    end else begin
      case (state_reg)
        SEARCH: begin
          // The frame in progress when tracking starts is never scored.
          if (vfall) begin
            state_next       = TRACK;
            good_frames_next = 4'd0;
          end
        end
        TRACK: begin
          if (bad_line || frame_bad) begin
            good_frames_next = 4'd0;
          end else if (vfall) begin
            good_frames_next = good_frames_reg + 4'd1;
            if (({1'b0, good_frames_reg} + 5'd1) == LOCK_W) begin
              state_next = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (bad_line || frame_bad) begin
            state_next       = TRACK;
            good_frames_next = 4'd0;
          end
        end
        default: begin
          state_next       = SEARCH;
          good_frames_next = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= SEARCH;
      good_frames_reg <= 4'd0;
    end else begin
      state_reg       <= state_next;
      good_frames_reg <= good_frames_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Error statistics
  // ---------------------------------------------------------------------------
`ifdef VGA_DEC_STATS_EN
  logic       scoring;
  logic       count_line;
  logic       count_frame;
  logic       line_counted_reg, line_counted_next;
  logic [7:0] err_count_reg, err_count_next;
  logic [8:0] err_sum;

  assign scoring = (state_reg != SEARCH) && !sync_lost;

  // A line can fail twice (run length at defall, length at hfall); it is
  // counted once. The frame it belongs to is counted separately at vfall.
  always_comb begin
    count_line        = scoring & bad_line & ~line_counted_reg;
    count_frame       = scoring & frame_bad;
    line_counted_next = hfall ? 1'b0 : (line_counted_reg | (scoring & line_bad_de));
    err_sum           = {1'b0, err_count_reg} + {8'd0, count_line} + {8'd0, count_frame};
    err_count_next    = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      line_counted_reg <= 1'b0;
      err_count_reg    <= 8'd0;
    end else begin
      line_counted_reg <= line_counted_next;
      err_count_reg    <= err_count_next;
    end
  end

  assign err_count = err_count_reg;
`else
  assign err_count = 8'd0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pixel_valid  = pixel_valid_reg;
  assign x            = x_reg;
  assign y            = y_reg;
  assign frame_start  = frame_start_reg;
  assign locked       = (state_reg == LOCKED);
  assign h_total_meas = h_total_meas_reg;
  assign v_total_meas = v_total_meas_reg;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Drives a reduced-size VGA timing stream (40 x 20 total, 24 x 12 visible) into
// vga_sync_decoder. Every active pixel driven pushes its expected (x, y) into a
// scoreboard queue that is popped when pixel_valid appears. Lock, measurement,
// frame_start and err_count expectations are written from the stream shape.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int HT   = 40;  // clocks per line
  localparam int VT   = 20;  // lines per frame
  localparam int HV   = 24;  // visible pixels per line
  localparam int VV   = 12;  // visible lines per frame
  localparam int HS_W = 4;   // hsync low width, starting at h = 0
  localparam int VS_W = 2;   // vsync low width in lines, starting at v = 0
  localparam int HA   = 8;   // first visible column
  localparam int VA   = 3;   // first visible line

`ifdef VGA_DEC_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic       clk_25 = 1'b0;
  logic       rst_n;
  logic       hSync;
  logic       vSync;
  logic       video_on;
  logic       pixel_valid;
  logic [9:0] x;
  logic [8:0] y;
  logic       frame_start;
  logic       locked;
  logic [9:0] h_total_meas;
  logic [9:0] v_total_meas;
  logic [7:0] err_count;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          frame_no     = 0;
  int          exp_h_meas;
  int          exp_v_meas;
  logic [18:0] sb_q[$];
  logic [18:0] sb_exp;

  vga_sync_decoder #(
    .H_TOTAL    (HT),
    .V_TOTAL    (VT),
    .H_VISIBLE  (HV),
    .V_VISIBLE  (VV),
    .LOCK_FRAMES(2)
  ) dut (
    .clk_25      (clk_25),
    .rst_n       (rst_n),
    .hSync       (hSync),
    .vSync       (vSync),
    .video_on    (video_on),
    .pixel_valid (pixel_valid),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .locked      (locked),
    .h_total_meas(h_total_meas),
    .v_total_meas(v_total_meas),
    .err_count   (err_count)
  );

  always #20 clk_25 = ~clk_25;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every registered pixel must match the oldest entry.
  always @(negedge clk_25) begin
    if (rst_n === 1'b1 && pixel_valid === 1'b1) begin
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        sb_exp = sb_q.pop_front();
        check_eq("pix_x", 32'(x), 32'(sb_exp[9:0]));
        check_eq("pix_y", 32'(y), 32'(sb_exp[18:10]));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
    check_eq({tag, "_x"}, 32'(x), 32'd0);
    check_eq({tag, "_y"}, 32'(y), 32'd0);
    check_eq({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check_eq({tag, "_locked"}, 32'(locked), 32'd0);
    check_eq({tag, "_h_meas"}, 32'(h_total_meas), 32'd0);
    check_eq({tag, "_v_meas"}, 32'(v_total_meas), 32'd0);
    check_eq({tag, "_err"}, 32'(err_count), 32'd0);
  endtask

  task automatic idle_inputs();
    hSync    = 1'b1;
    vSync    = 1'b1;
    video_on = 1'b0;
  endtask

  // One frame starting at its vsync/hsync fall. Outputs are sampled 1 time unit
  // after each rising edge, before the next cycle's inputs are driven.
  //   lines       number of lines in the frame
  //   long_line   index of a line stretched to HT+1 clocks (-1: none)
  //   lock_before locked expected just before this frame's vfall is seen
  //   lock_after  locked expected one cycle after this frame's vfall
  //   abort_at    stop driving at this cycle index, mid-frame (-1: none)
  task automatic drive_frame(input int lines, input int long_line, input bit lock_before,
                             input bit lock_after, input int abort_at);
    int c;
    int len;
    c = 0;
    frame_no++;
    for (int v = 0; v < lines; v++) begin
      len = (v == long_line) ? HT + 1 : HT;
      for (int h = 0; h < len; h++) begin
        @(posedge clk_25);
        #1;
        if (c == 0) check_eq("lock_before_vfall", 32'(locked), 32'(lock_before));
        if (c == 1) begin
          check_eq("lock_after_vfall", 32'(locked), 32'(lock_after));
          check_eq("frame_start_pulse", 32'(frame_start), 32'd1);
          if (exp_h_meas >= 0) check_eq("h_total_meas", 32'(h_total_meas), 32'(exp_h_meas));
          if (exp_v_meas >= 0) check_eq("v_total_meas", 32'(v_total_meas), 32'(exp_v_meas));
        end
        if (c == 2) check_eq("frame_start_one_cycle", 32'(frame_start), 32'd0);
        if (long_line >= 0 && v == long_line + 1 && h == 1) begin
          check_eq("h_meas_long_line", 32'(h_total_meas), 32'(HT + 1));
          check_eq("lock_drop_long_line", 32'(locked), 32'd0);
        end
        if (c == abort_at) begin
          $display("[TB] frame %0d aborted at cycle %0d (line %0d col %0d)", frame_no, c, v, h);
          return;
        end
        hSync    = (h >= HS_W);
        vSync    = (v >= VS_W);
        video_on = (h >= HA) && (h < HA + HV) && (v >= VA) && (v < VA + VV);
        if (video_on) sb_q.push_back({9'(v - VA), 10'(h - HA)});
        c++;
      end
    end
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    exp_h_meas = HT;
    exp_v_meas = lines;
    $display("[TB] frame %0d: %0d lines, long_line %0d, locked %0b, h_meas %0d, v_meas %0d, err %0d",
             frame_no, lines, long_line, locked, h_total_meas, v_total_meas, err_count);
  endtask

  initial begin
    rst_n      = 1'b0;
    exp_h_meas = -1;
    exp_v_meas = -1;
    idle_inputs();
    repeat (3) @(posedge clk_25);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk_25);
    #1;

    // Acquire: first vfall only starts tracking, lock one cycle after 2nd scored vfall.
    drive_frame(VT, -1, 1'b0, 1'b0, -1);
    drive_frame(VT, -1, 1'b0, 1'b0, -1);
    drive_frame(VT, -1, 1'b0, 1'b1, -1);

    // One line one clock too long: lock drops, bad line then bad frame counted.
    drive_frame(VT, 5, 1'b1, 1'b1, -1);
    check_eq("err_after_bad_line", 32'(err_count), 32'(STATS * 1));
    drive_frame(VT, -1, 1'b0, 1'b0, -1);
    check_eq("err_after_bad_frame", 32'(err_count), 32'(STATS * 2));
    drive_frame(VT, -1, 1'b0, 1'b0, -1);
    drive_frame(VT, -1, 1'b0, 1'b1, -1);

    // hSync stuck high: lock held until the line counter saturates.
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clk_25);
      #1;
      if (i == 500) check_eq("lock_during_hold", 32'(locked), 32'd1);
      idle_inputs();
    end
    @(posedge clk_25);
    #1;
    check_eq("lock_after_sync_loss", 32'(locked), 32'd0);
    check_eq("h_meas_held", 32'(h_total_meas), 32'(HT));
    $display("[TB] hsync held high 1100 clocks, locked %0b, h_meas %0d", locked, h_total_meas);
    exp_h_meas = 1023;

    // Recover, relock, then a 19-line frame breaks lock.
    drive_frame(VT, -1, 1'b0, 1'b0, -1);
    drive_frame(VT, -1, 1'b0, 1'b0, -1);
    drive_frame(VT, -1, 1'b0, 1'b1, -1);
    drive_frame(VT - 1, -1, 1'b1, 1'b1, -1);
    drive_frame(VT, -1, 1'b1, 1'b0, VA * HT + 12);
    check_eq("err_after_short_frame", 32'(err_count), 32'(STATS * 3));

    // Reset in the middle of an active line clears every output at once.
    rst_n = 1'b0;
    #1;
    check_all_zero("midline_reset");
    sb_q.delete();
    idle_inputs();
    repeat (3) @(posedge clk_25);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk_25);
    #1;
    check_eq("post_reset_locked", 32'(locked), 32'd0);
    check_eq("post_reset_pixel_valid", 32'(pixel_valid), 32'd0);
    check_eq("post_reset_err", 32'(err_count), 32'd0);
    $display("[TB] reset mid-line, outputs cleared");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
